apb_periph_xbar: RTL and testbench
==================================

# apb_periph_xbar

Parametrised, registered APB 1-to-N peripheral crossbar that replaces the fixed-slot peripheral bus wrapper. It takes one upstream APB master port, decodes the address against `NB_SLAVES` runtime-supplied address windows, and replays the transfer on exactly one downstream slave port. It adds a decode-error response and an optional access timeout. It sits between the AXI-to-APB bridge and the SoC peripherals: UART, GPIO, timer, event unit, SoC control, debug and any future additions.

## Interface
Parameters:
- `NB_SLAVES`, 6: number of downstream ports, 1..32
- `APB_ADDR_WIDTH`, 32: address width
- `APB_DATA_WIDTH`, 32: data width
- `TIMEOUT_CYCLES`, 255: maximum ACCESS wait cycles before abort, 1..65535; used only with the timeout feature

Ports:
- `clk_i` in 1: clock
- `rst_i` in 1: reset, synchronous, active-high
- `start_addr_i` in `NB_SLAVES`×`APB_ADDR_WIDTH`: window base, inclusive
- `end_addr_i` in `NB_SLAVES`×`APB_ADDR_WIDTH`: window end, inclusive
- `s_psel_i`, `s_penable_i`, `s_pwrite_i` in 1 each: upstream control
- `s_paddr_i` in `APB_ADDR_WIDTH`; `s_pwdata_i` in `APB_DATA_WIDTH`
- `s_prdata_o` out `APB_DATA_WIDTH`; `s_pready_o`, `s_pslverr_o` out 1
- `m_psel_o` out `NB_SLAVES`: one-hot downstream select
- `m_penable_o`, `m_pwrite_o` out 1: shared by all slaves
- `m_paddr_o` out `APB_ADDR_WIDTH`; `m_pwdata_o` out `APB_DATA_WIDTH`: shared
- `m_prdata_i` in `NB_SLAVES`×`APB_DATA_WIDTH`; `m_pready_i`, `m_pslverr_i` in `NB_SLAVES`
- `dec_err_o` out 1: one-cycle pulse on a decode miss
- `timeout_o` out 1: one-cycle pulse on timeout abort; tied to 0 when the feature is compiled out

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: on `s_psel_i & ~s_penable_i`, register addr, wdata, write and the decoded index.
  - Hit: go to SETUP.
  - Miss: go to RESP with error flag set and `dec_err_o` pulsed.
- Decode: hit when `start ≤ addr ≤ end`, unsigned full-width compare. If windows overlap, the lowest index wins. A window with `start > end` never matches.
- SETUP: `m_psel_o[idx]`=1, `m_penable_o`=0, for one cycle, then ACCESS.
- ACCESS: `m_psel_o[idx]`=1, `m_penable_o`=1. On `m_pready_i[idx]`, capture `m_prdata_i[idx]` and `m_pslverr_i[idx]`, then go to RESP.
- RESP: `s_pready_o`=1 for one cycle, driving the captured `s_prdata_o` and `s_pslverr_o`. Return to IDLE.
- Decode error: `s_prdata_o`=0, `s_pslverr_o`=1. No downstream port is touched.
- `s_pready_o` is 0 in every state other than RESP.
- Upstream signal changes after capture are ignored until RESP. This is legal, because an APB master holds its signals until pready.
- `m_paddr_o`, `m_pwdata_o` and `m_pwrite_o` come from registers. They hold the last values while in IDLE.
- `m_pready_i` and `m_pslverr_i` of non-selected slaves are ignored.

## Timing
- Reset state is IDLE. All outputs are 0, and all capture registers and the timeout counter are cleared.
- Reset asserted in any state returns the block to IDLE on the next edge. The downstream `m_psel_o` drops immediately with no upstream response; the upstream master is reset together with this block.
- Zero-wait slave, measured from the upstream setup cycle T0:
  - T1: SETUP.
  - T2: ACCESS, slave pready.
  - T3: `s_pready_o`=1.
  - The upstream transfer takes 4 cycles. Each downstream wait cycle adds 1.
- Decode miss: `s_pready_o` at T1.
- Back-to-back transfers: a new upstream setup is accepted in the IDLE cycle after RESP. Minimum spacing is one idle cycle per transfer.

## Configuration
- Macro: `APB_XBAR_TIMEOUT_EN`.
- When defined:
  - A 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle without pready.
  - When the count equals `TIMEOUT_CYCLES`, the block drops `m_psel_o`/`m_penable_o` in the same cycle and goes to RESP with `s_pslverr_o`=1 and `s_prdata_o`=0. `timeout_o` pulses.
  - If pready and the limit coincide, pready wins.
- When undefined: no counter exists, ACCESS waits indefinitely, and `timeout_o`=0.

## Structure
- Package `apb_xbar_pkg`:
  - FSM state enum `xbar_state_e`
  - `XBAR_IDX_W = $clog2(NB_SLAVES)` helper function
  - Decode-error read data constant, 0
  - Timeout counter width constant, 16
- Sub-module `apb_addr_decoder`: combinational. Inputs are the address and the window arrays; outputs are `hit` and `idx` with lowest-index priority. It is instantiated once.

## Test plan
- Windows 0x1A10_0000..0x1A10_0FFF on port 0 and 0x1A10_1000..0x1A10_1FFF on port 1. Read 0x1A10_1004 with zero-wait slave 1 returning 0xCAFE_0001 -> only `m_psel_o[1]` toggles, and `s_prdata_o`=0xCAFE_0001 with pready at T3.
- Write 0x1A10_0008 with data 0x55AA to slave 0, inserting 3 wait cycles -> `m_pwdata_o`=0x55AA throughout, and `s_pready_o` arrives at T6 with `pslverr`=0.
- Access 0x2000_0000, unmapped -> `dec_err_o` pulse, `s_pready_o` at T1 with `pslverr`=1 and `prdata`=0, and `m_psel_o` stays 0.
- Port 2 window 0x1A10_0000..0x1A10_FFFF overlapping port 0; access 0x1A10_0010 -> port 0 is selected.
- With `APB_XBAR_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, slave never ready -> abort after the 4th ACCESS cycle, `timeout_o` pulse, `pslverr`=1. The next transfer to another port completes normally.
- Assert `rst_i` during ACCESS -> next cycle all outputs are 0, the state is IDLE, and a following transfer completes in 4 cycles.

Source files
------------

// File: rtl/apb_xbar_pkg.sv
// Shared types and constants for the APB 1-to-N peripheral crossbar.
package apb_xbar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } xbar_state_e;

  // Width of the access timeout counter
  localparam int TIMEOUT_CNT_W = 16;

  // Read data returned on a decode miss or a timeout abort
  localparam int DEC_ERR_RDATA = 0;

  // Width of a slave index; a single-slave build still needs one bit
  function automatic int xbar_idx_w(input int nb_slaves);
    return (nb_slaves > 1) ? $clog2(nb_slaves) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational window decoder: finds the lowest-index window holding the address.
module apb_addr_decoder
  import apb_xbar_pkg::*;
#(
  parameter int NB_SLAVES      = 6,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int IDX_W          = xbar_idx_w(NB_SLAVES)
) (
  input  logic [APB_ADDR_WIDTH-1:0]           addr_i,
  input  logic [NB_SLAVES*APB_ADDR_WIDTH-1:0] start_addr_i,
  input  logic [NB_SLAVES*APB_ADDR_WIDTH-1:0] end_addr_i,
  output logic                                hit_o,
  output logic [IDX_W-1:0]                    idx_o
);

  // Scan from the top so the lowest matching index overwrites the others; start > end never matches
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NB_SLAVES - 1; i >= 0; i--) begin
      if ((addr_i >= start_addr_i[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]) &&
          (addr_i <= end_addr_i[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH])) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/apb_periph_xbar.sv
// Registered APB 1-to-N peripheral crossbar with decode-error response.
// Optional access timeout is enabled by defining APB_XBAR_TIMEOUT_EN.
module apb_periph_xbar
  import apb_xbar_pkg::*;
#(
  parameter int NB_SLAVES      = 6,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NB_SLAVES*APB_ADDR_WIDTH-1:0] start_addr_i,
  input  logic [NB_SLAVES*APB_ADDR_WIDTH-1:0] end_addr_i,
  input  logic                                s_psel_i,
  input  logic                                s_penable_i,
  input  logic                                s_pwrite_i,
  input  logic [APB_ADDR_WIDTH-1:0]           s_paddr_i,
  input  logic [APB_DATA_WIDTH-1:0]           s_pwdata_i,
  output logic [APB_DATA_WIDTH-1:0]           s_prdata_o,
  output logic                                s_pready_o,
  output logic                                s_pslverr_o,
  output logic [NB_SLAVES-1:0]                m_psel_o,
  output logic                                m_penable_o,
  output logic                                m_pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0]           m_paddr_o,
  output logic [APB_DATA_WIDTH-1:0]           m_pwdata_o,
  input  logic [NB_SLAVES*APB_DATA_WIDTH-1:0] m_prdata_i,
  input  logic [NB_SLAVES-1:0]                m_pready_i,
  input  logic [NB_SLAVES-1:0]                m_pslverr_i,
  output logic                                dec_err_o,
  output logic                                timeout_o
);

  localparam int IDX_W = xbar_idx_w(NB_SLAVES);

  xbar_state_e               state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                      write_q, write_d;
  logic [NB_SLAVES-1:0]      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      pready_q, pready_d;
  logic [APB_DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                      pslverr_q, pslverr_d;
  logic                      dec_err_q, dec_err_d;

  logic                      dec_hit;
  logic [IDX_W-1:0]          dec_idx;
  logic                      sel_pready;
  logic                      sel_pslverr;
  logic [APB_DATA_WIDTH-1:0] sel_prdata;

`ifdef APB_XBAR_TIMEOUT_EN
  logic [TIMEOUT_CNT_W-1:0]  cnt_q, cnt_d;
  logic                      timeout_q, timeout_d;
`else
  logic                      unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  apb_addr_decoder #(
    .NB_SLAVES      (NB_SLAVES),
    .APB_ADDR_WIDTH (APB_ADDR_WIDTH),
    .IDX_W          (IDX_W)
  ) u_decoder (
    .addr_i       (s_paddr_i),
    .start_addr_i (start_addr_i),
    .end_addr_i   (end_addr_i),
    .hit_o        (dec_hit),
    .idx_o        (dec_idx)
  );

  // Only the captured slave's response is looked at; the others are don't-care
  always_comb begin
    sel_pready  = m_pready_i[idx_q];
    sel_pslverr = m_pslverr_i[idx_q];
    sel_prdata  = m_prdata_i[int'(idx_q)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
  end

  // Next-state and next-output logic; every output is a flop so downstream timing starts clean
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    prdata_d  = prdata_q;
    pslverr_d = pslverr_q;
    pready_d  = 1'b0;
    dec_err_d = 1'b0;
`ifdef APB_XBAR_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        psel_d    = '0;
        penable_d = 1'b0;
        prdata_d  = '0;
        pslverr_d = 1'b0;
        if (s_psel_i && !s_penable_i) begin
          addr_d  = s_paddr_i;
          wdata_d = s_pwdata_i;
          write_d = s_pwrite_i;
          idx_d   = dec_idx;
          if (dec_hit) begin
            state_d         = ST_SETUP;
            psel_d[dec_idx] = 1'b1;
          end else begin
            state_d   = ST_RESP;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            prdata_d  = APB_DATA_WIDTH'(DEC_ERR_RDATA);
            dec_err_d = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
`ifdef APB_XBAR_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ST_ACCESS: begin
        if (sel_pready) begin
          state_d   = ST_RESP;
          psel_d    = '0;
          penable_d = 1'b0;
          pready_d  = 1'b1;
          prdata_d  = sel_prdata;
          pslverr_d = sel_pslverr;
        end
`ifdef APB_XBAR_TIMEOUT_EN
        else if ((cnt_q + 1'b1) == TIMEOUT_CNT_W'(TIMEOUT_CYCLES)) begin
          state_d   = ST_RESP;
          psel_d    = '0;
          penable_d = 1'b0;
          pready_d  = 1'b1;
          prdata_d  = APB_DATA_WIDTH'(DEC_ERR_RDATA);
          pslverr_d = 1'b1;
          timeout_d = 1'b1;
          cnt_d     = cnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_RESP: begin
        state_d   = ST_IDLE;
        prdata_d  = '0;
        pslverr_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      dec_err_q <= 1'b0;
`ifdef APB_XBAR_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      dec_err_q <= dec_err_d;
`ifdef APB_XBAR_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign s_prdata_o  = prdata_q;
  assign s_pready_o  = pready_q;
  assign s_pslverr_o = pslverr_q;
  assign m_psel_o    = psel_q;
  assign m_penable_o = penable_q;
  assign m_pwrite_o  = write_q;
  assign m_paddr_o   = addr_q;
  assign m_pwdata_o  = wdata_q;
  assign dec_err_o   = dec_err_q;
`ifdef APB_XBAR_TIMEOUT_EN
  assign timeout_o   = timeout_q;
`else
  assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_apb_periph_xbar.sv
// Scoreboard testbench for apb_periph_xbar (timeout case runs when APB_XBAR_TIMEOUT_EN is defined).
module tb_apb_periph_xbar;

  localparam int NB = 6;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
    logic [NB-1:0] psel;
    logic          dec;
    logic          tmo;
  } exp_t;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NB*AW-1:0]  start_addr;
  logic [NB*AW-1:0]  end_addr;
  logic              s_psel, s_penable, s_pwrite;
  logic [AW-1:0]     s_paddr;
  logic [DW-1:0]     s_pwdata;
  logic [DW-1:0]     s_prdata_o;
  logic              s_pready_o, s_pslverr_o;
  logic [NB-1:0]     m_psel_o;
  logic              m_penable_o, m_pwrite_o;
  logic [AW-1:0]     m_paddr_o;
  logic [DW-1:0]     m_pwdata_o;
  logic [NB*DW-1:0]  m_prdata_i;
  logic [NB-1:0]     m_pready_i, m_pslverr_i;
  logic              dec_err_o, timeout_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  exp_t exp_q[$];

  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata;
  logic          cur_write;

  logic [DW-1:0] slv_rdata [NB];
  int            slv_wait  [NB];
  logic          slv_err   [NB];
  logic          slv_never [NB];

  apb_periph_xbar #(
    .NB_SLAVES      (NB),
    .APB_ADDR_WIDTH (AW),
    .APB_DATA_WIDTH (DW),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_addr_i (start_addr),
    .end_addr_i   (end_addr),
    .s_psel_i     (s_psel),
    .s_penable_i  (s_penable),
    .s_pwrite_i   (s_pwrite),
    .s_paddr_i    (s_paddr),
    .s_pwdata_i   (s_pwdata),
    .s_prdata_o   (s_prdata_o),
    .s_pready_o   (s_pready_o),
    .s_pslverr_o  (s_pslverr_o),
    .m_psel_o     (m_psel_o),
    .m_penable_o  (m_penable_o),
    .m_pwrite_o   (m_pwrite_o),
    .m_paddr_o    (m_paddr_o),
    .m_pwdata_o   (m_pwdata_o),
    .m_prdata_i   (m_prdata_i),
    .m_pready_i   (m_pready_i),
    .m_pslverr_i  (m_pslverr_i),
    .dec_err_o    (dec_err_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // One comparison: counts it and reports a mismatch
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mkExp(input logic [DW-1:0] rdata, input logic err, input int lat,
                                 input logic [NB-1:0] psel, input logic dec, input logic tmo);
    exp_t e;
    e.rdata = rdata; e.err = err; e.lat = lat; e.psel = psel; e.dec = dec; e.tmo = tmo;
    return e;
  endfunction

  // Full APB master transfer; expectation is queued for the monitor
  task automatic applyStimulus(input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input logic write, input exp_t e);
    bit got;
    exp_q.push_back(e);
    @(posedge clk_i); #1;
    cur_addr = addr; cur_wdata = wdata; cur_write = write;
    s_psel = 1'b1; s_penable = 1'b0; s_paddr = addr; s_pwdata = wdata; s_pwrite = write;
    t0 = cyc;
    @(posedge clk_i); #1;
    s_penable = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk_i);
      if (s_pready_o) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk_i); #1;
    s_psel = 1'b0; s_penable = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL pready_wait: actual no pready within 64 cycles required pready for 0x%0h", addr);
      void'(exp_q.pop_back());
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_psel"}, 64'(m_psel_o), 64'h0);
    checkOutput({tag, "_ctrl"}, 64'({m_penable_o, m_pwrite_o, s_pready_o, s_pslverr_o, dec_err_o, timeout_o}), 64'h0);
    checkOutput({tag, "_paddr"}, 64'(m_paddr_o), 64'h0);
    checkOutput({tag, "_pwdata"}, 64'(m_pwdata_o), 64'h0);
    checkOutput({tag, "_prdata"}, 64'(s_prdata_o), 64'h0);
  endtask

  // Downstream slave models; unselected ports present a poisoned response that must be ignored
  initial begin
    int acc;
    acc = 0;
    m_pready_i = '1; m_pslverr_i = '1; m_prdata_i = '1;
    forever begin
      @(posedge clk_i); #1;
      for (int p = 0; p < NB; p++) begin
        if (!m_psel_o[p]) begin
          m_pready_i[p] = 1'b1;
          m_pslverr_i[p] = 1'b1;
          m_prdata_i[p*DW +: DW] = 32'hDEAD_BEEF;
        end else if (m_penable_o && !slv_never[p] && acc == slv_wait[p]) begin
          m_pready_i[p] = 1'b1;
          m_pslverr_i[p] = slv_err[p];
          m_prdata_i[p*DW +: DW] = slv_rdata[p];
        end else begin
          m_pready_i[p] = 1'b0;
          m_pslverr_i[p] = 1'b0;
          m_prdata_i[p*DW +: DW] = '0;
        end
      end
      if (|m_psel_o && m_penable_o) acc++;
      else acc = 0;
    end
  end

  // Monitor: pops an expectation whenever the crossbar presents an upstream response
  initial begin
    logic [NB-1:0] seen;
    bit bus_bad;
    exp_t e;
    seen = '0;
    bus_bad = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        seen = '0;
        bus_bad = 1'b0;
      end else begin
        seen |= m_psel_o;
        if (|m_psel_o && (m_paddr_o !== cur_addr || m_pwdata_o !== cur_wdata || m_pwrite_o !== cur_write))
          bus_bad = 1'b1;
        if (s_pready_o) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_pready: actual pready=1 required no response");
          end else begin
            e = exp_q.pop_front();
            checkOutput("prdata", 64'(s_prdata_o), 64'(e.rdata));
            checkOutput("pslverr", 64'(s_pslverr_o), 64'(e.err));
            checkOutput("latency", 64'(cyc - t0), 64'(e.lat));
            checkOutput("psel_seen", 64'(seen), 64'(e.psel));
            checkOutput("dec_err", 64'(dec_err_o), 64'(e.dec));
            checkOutput("timeout", 64'(timeout_o), 64'(e.tmo));
            checkOutput("bus_stable", 64'(bus_bad), 64'h0);
          end
          seen = '0;
          bus_bad = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual simulation still running required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int p = 0; p < NB; p++) begin
      slv_rdata[p] = 32'h1000_0000 + p; slv_wait[p] = 0; slv_err[p] = 1'b0; slv_never[p] = 1'b0;
    end
    start_addr[0*AW +: AW] = 32'h1A10_0000; end_addr[0*AW +: AW] = 32'h1A10_0FFF;
    start_addr[1*AW +: AW] = 32'h1A10_1000; end_addr[1*AW +: AW] = 32'h1A10_1FFF;
    start_addr[2*AW +: AW] = 32'h1A10_0000; end_addr[2*AW +: AW] = 32'h1A10_FFFF;
    start_addr[3*AW +: AW] = 32'h2000_0010; end_addr[3*AW +: AW] = 32'h1FFF_FFF0;
    start_addr[4*AW +: AW] = 32'h4000_0000; end_addr[4*AW +: AW] = 32'h4000_00FF;
    start_addr[5*AW +: AW] = 32'h5000_0000; end_addr[5*AW +: AW] = 32'h5000_0000;
    s_psel = 1'b0; s_penable = 1'b0; s_pwrite = 1'b0; s_paddr = '0; s_pwdata = '0;
    cur_addr = '0; cur_wdata = '0; cur_write = 1'b0;
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkResetState("reset");
    rst_i = 1'b0;

    // Zero-wait read from port 1
    slv_rdata[1] = 32'hCAFE_0001;
    applyStimulus(32'h1A10_1004, 32'h0, 1'b0, mkExp(32'hCAFE_0001, 1'b0, 3, 6'b000010, 1'b0, 1'b0));
    @(negedge clk_i);
    checkOutput("idle_hold_paddr", 64'(m_paddr_o), 64'h1A10_1004);

    // Write to port 0 with three wait cycles
    slv_wait[0] = 3; slv_rdata[0] = 32'h0000_0A00;
    applyStimulus(32'h1A10_0008, 32'h0000_55AA, 1'b1, mkExp(32'h0000_0A00, 1'b0, 6, 6'b000001, 1'b0, 1'b0));
    @(negedge clk_i);
    checkOutput("idle_hold_pwdata", 64'(m_pwdata_o), 64'h55AA);
    slv_wait[0] = 0;

    // Unmapped address: inverted window 3 must not match either
    applyStimulus(32'h2000_0000, 32'h1234, 1'b1, mkExp(32'h0, 1'b1, 1, 6'b000000, 1'b1, 1'b0));

    // Overlap between port 0 and port 2 resolves to port 0
    slv_rdata[0] = 32'h0000_0B0B;
    applyStimulus(32'h1A10_0010, 32'h0, 1'b0, mkExp(32'h0000_0B0B, 1'b0, 3, 6'b000001, 1'b0, 1'b0));

    // Address above port 0 but inside port 2
    slv_rdata[2] = 32'h2222_2222;
    applyStimulus(32'h1A10_8000, 32'h0, 1'b0, mkExp(32'h2222_2222, 1'b0, 3, 6'b000100, 1'b0, 1'b0));

    // Inclusive end of window 4 with slave error, then one past the end
    slv_err[4] = 1'b1; slv_rdata[4] = 32'h4444_0000;
    applyStimulus(32'h4000_00FF, 32'h0, 1'b0, mkExp(32'h4444_0000, 1'b1, 3, 6'b010000, 1'b0, 1'b0));
    applyStimulus(32'h4000_0100, 32'h0, 1'b0, mkExp(32'h0, 1'b1, 1, 6'b000000, 1'b1, 1'b0));

    // Single-address window on port 5 with one wait cycle
    slv_wait[5] = 1; slv_rdata[5] = 32'h5555_AAAA;
    applyStimulus(32'h5000_0000, 32'h0, 1'b0, mkExp(32'h5555_AAAA, 1'b0, 4, 6'b100000, 1'b0, 1'b0));

`ifdef APB_XBAR_TIMEOUT_EN
    // Port 1 never answers: four ACCESS cycles then abort
    slv_never[1] = 1'b1;
    applyStimulus(32'h1A10_1000, 32'h0, 1'b0, mkExp(32'h0, 1'b1, 6, 6'b000010, 1'b0, 1'b1));
    slv_never[1] = 1'b0;
    applyStimulus(32'h1A10_0000, 32'h0, 1'b0, mkExp(32'h0000_0B0B, 1'b0, 3, 6'b000001, 1'b0, 1'b0));
`endif

    // Reset during ACCESS with a stalled slave
    slv_never[1] = 1'b1;
    @(posedge clk_i); #1;
    cur_addr = 32'h1A10_1008; cur_wdata = 32'h77; cur_write = 1'b1;
    s_psel = 1'b1; s_penable = 1'b0; s_paddr = 32'h1A10_1008; s_pwdata = 32'h77; s_pwrite = 1'b1;
    @(posedge clk_i); #1;
    s_penable = 1'b1;
    @(posedge clk_i); #1;
    checkOutput("access_before_reset", 64'({m_psel_o, m_penable_o}), 64'({6'b000010, 1'b1}));
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    checkResetState("mid_reset");
    rst_i = 1'b0;
    s_psel = 1'b0; s_penable = 1'b0;
    slv_never[1] = 1'b0;
    slv_rdata[1] = 32'hCAFE_0002;
    applyStimulus(32'h1A10_1004, 32'h0, 1'b0, mkExp(32'hCAFE_0002, 1'b0, 3, 6'b000010, 1'b0, 1'b0));

    repeat (3) @(posedge clk_i);
    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
